// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
package shift_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned SHAMT_W     = 5;
  localparam logic        REQ_EX      = 1'b0;
  localparam logic        REQ_AUX     = 1'b1;
  localparam logic [1:0]  ENC_ILLEGAL = 2'b10;

endpackage

// File: rtl/shift_arbiter_shift_unit.sv
// Combinational RV32 shifter: SLL / SRL / SRA selected by {funct7_5, funct3_2}.
module Shift_Unit
  import shift_arb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic               En,
  input  logic [XLEN-1:0]    Rs1,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic               Funct3_2,
  input  logic               Funct7_5,
  output logic [XLEN-1:0]    Result
);

  always_comb begin
    Result = '0;
    if (En) begin
      unique case ({Funct7_5, Funct3_2})
        2'b00:   Result = Rs1 << Shamt;
        2'b01:   Result = Rs1 >> Shamt;
        2'b11:   Result = $unsigned($signed(Rs1) >>> Shamt);
        default: Result = '0;
      endcase
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one Shift_Unit between the execute stage and
// the address/CSR helper path, with valid/ready on both request and response.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic [1:0]           Req_Valid,
  output logic [1:0]           Req_Ready,
  input  logic [2*XLEN-1:0]    Req_Rs1,
  input  logic [2*SHAMT_W-1:0] Req_Shamt,
  input  logic [1:0]           Req_Funct3_2,
  input  logic [1:0]           Req_Funct7_5,
  output logic [1:0]           Resp_Valid,
  input  logic [1:0]           Resp_Ready,
  output logic [XLEN-1:0]      Resp_Result,
  output logic                 Resp_Err,
  output logic                 Busy
);

  state_t               state, state_nxt;
  logic                 last_grant;
  logic                 owner;
  logic [XLEN-1:0]      op_rs1;
  logic [SHAMT_W-1:0]   op_shamt;
  logic                 op_f3;
  logic                 op_f7;
  logic [XLEN-1:0]      su_result;
  logic                 gnt_vld;
  logic                 gnt;
  logic                 accept;

  // Returns {grant_valid, grant_index}; on contention the requester that
  // did not win last time is chosen.
  function automatic logic [1:0] pick(input logic [1:0] valid, input logic last);
    logic [1:0] r;
    r = 2'b00;
    unique case (valid)
      2'b01:   r = {1'b1, REQ_EX};
      2'b10:   r = {1'b1, REQ_AUX};
      2'b11:   r = {1'b1, ~last};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  assign {gnt_vld, gnt} = pick(Req_Valid, last_grant);

  always_comb begin
    state_nxt = state;
    Req_Ready = '0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_vld) begin
          Req_Ready[gnt] = 1'b1;
          accept         = 1'b1;
          state_nxt      = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: if (Resp_Ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= REQ_AUX;
      owner       <= REQ_EX;
      op_rs1      <= '0;
      op_shamt    <= '0;
      op_f3       <= 1'b0;
      op_f7       <= 1'b0;
      Resp_Result <= '0;
      Resp_Err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= gnt;
        last_grant <= gnt;
        op_rs1     <= Req_Rs1[gnt*XLEN +: XLEN];
        op_shamt   <= Req_Shamt[gnt*SHAMT_W +: SHAMT_W];
        op_f3      <= Req_Funct3_2[gnt];
        op_f7      <= Req_Funct7_5[gnt];
      end
      if (state == EXEC) begin
        Resp_Result <= su_result;
        Resp_Err    <= ({op_f7, op_f3} == ENC_ILLEGAL);
      end
    end
  end

  Shift_Unit #(.XLEN(XLEN)) u_shift (
    .En       (state == EXEC),
    .Rs1      (op_rs1),
    .Shamt    (op_shamt),
    .Funct3_2 (op_f3),
    .Funct7_5 (op_f7),
    .Result   (su_result)
  );

  assign Resp_Valid = (state != RESP)  ? 2'b00 :
                      (owner == REQ_AUX) ? 2'b10 : 2'b01;
  assign Busy       = (state != IDLE);

endmodule
